// File: rtl/led_breathe_sequencer.sv
// LED breathing-pattern sequencer.
// Each step strobe advances a ramp-up / hold-high / ramp-down / hold-low duty pattern;
// a free-running PWM counter turns the current duty into a pulse train on nLED.
// Optional build macro LED_BREATHE_GAMMA_EN squares the duty (>> PWM_BITS) before it
// reaches the PWM comparator, for perceptually linear brightness.
module led_breathe_sequencer #(
  parameter int unsigned PWM_BITS   = 8,
  parameter int unsigned HOLD_TICKS = 16,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                stepPulse,
  output logic                nLED,
  output logic [PWM_BITS-1:0] duty,
  output logic [1:0]          phase,
  output logic                cycleDone
);

  localparam logic [PWM_BITS-1:0] MaxVal   = '1;
  localparam logic [PWM_BITS-1:0] OneVal   = PWM_BITS'(1);
  localparam logic [15:0]         HoldLast = 16'(HOLD_TICKS - 1);

  typedef enum logic [1:0] {
    StRampUp   = 2'd0,
    StHoldHigh = 2'd1,
    StRampDown = 2'd2,
    StHoldLow  = 2'd3
  } phase_e;

  phase_e              phase_q, phase_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [15:0]         hold_cnt_q, hold_cnt_d;
  logic                cycle_done_q, cycle_done_d;

  logic [PWM_BITS-1:0] pwm_cnt_q;
  logic [PWM_BITS-1:0] duty_latched_q;
  logic                nled_q;

  logic                step;
  logic [PWM_BITS-1:0] duty_eff;
  logic                lit;

  // A step only counts while the sequencer is enabled.
  assign step = stepPulse & enable;

`ifdef LED_BREATHE_GAMMA_EN
  logic [2*PWM_BITS-1:0] duty_sq;

  // Gamma correction: keep the upper half of the full-width square.
  assign duty_sq  = {{PWM_BITS{1'b0}}, duty_q} * {{PWM_BITS{1'b0}}, duty_q};
  assign duty_eff = duty_sq[2*PWM_BITS-1:PWM_BITS];
`else
  // Linear brightness: the pattern duty drives the comparator directly.
  assign duty_eff = duty_q;
`endif

  // Pattern state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q      <= StRampUp;
      duty_q       <= '0;
      hold_cnt_q   <= '0;
      cycle_done_q <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      duty_q       <= duty_d;
      hold_cnt_q   <= hold_cnt_d;
      cycle_done_q <= cycle_done_d;
    end
  end

  // Pattern next-state: advances only on a step event; cycleDone pulses on wrap to ramp-up.
  always_comb begin
    phase_d      = phase_q;
    duty_d       = duty_q;
    hold_cnt_d   = hold_cnt_q;
    cycle_done_d = 1'b0;
    if (step) begin
      unique case (phase_q)
        StRampUp: begin
          duty_d = duty_q + OneVal;
          if (duty_q == MaxVal - OneVal) begin
            phase_d    = StHoldHigh;
            hold_cnt_d = '0;
          end
        end
        StHoldHigh: begin
          if (hold_cnt_q == HoldLast) begin
            phase_d = StRampDown;
          end else begin
            hold_cnt_d = hold_cnt_q + 16'd1;
          end
        end
        StRampDown: begin
          duty_d = duty_q - OneVal;
          if (duty_q == OneVal) begin
            phase_d    = StHoldLow;
            hold_cnt_d = '0;
          end
        end
        StHoldLow: begin
          if (hold_cnt_q == HoldLast) begin
            phase_d      = StRampUp;
            cycle_done_d = 1'b1;
          end else begin
            hold_cnt_d = hold_cnt_q + 16'd1;
          end
        end
        default: phase_d = StRampUp;
      endcase
    end
  end

  // Free-running PWM counter (frozen while disabled); duty is captured only at the
  // last count so a new duty takes effect cleanly from count 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_q      <= '0;
      duty_latched_q <= '0;
    end else begin
      if (enable) begin
        pwm_cnt_q <= pwm_cnt_q + OneVal;
      end
      if (pwm_cnt_q == MaxVal) begin
        duty_latched_q <= duty_eff;
      end
    end
  end

  assign lit = enable & (pwm_cnt_q < duty_latched_q);

  // Registered LED drive; reset value is the unlit level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nled_q <= ACTIVE_LOW;
    end else begin
      nled_q <= ACTIVE_LOW ? ~lit : lit;
    end
  end

  assign nLED      = nled_q;
  assign duty      = duty_q;
  assign phase     = phase_q;
  assign cycleDone = cycle_done_q;

endmodule
